// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: 8-to-3 one-hot encoder on valid/ready streams with a small output FIFO,
// a per-word error flag and a saturating error counter.
module onehot_encoder_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       a,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0] a;
    logic       err;
  } ent_t;
  ent_t             mem_q [DEPTH];
  ent_t             head, hold_q, hold_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic [2:0]       enc_a;
  logic             enc_err, push, pop;
  always_comb begin
    enc_a = 3'd0;
    for (int i = 0; i < 8; i++) enc_a = d[i] ? 3'(i) : enc_a;
    enc_err = (d == 8'd0) || |(d & (d - 8'd1));
  end
  assign in_ready  = !rst && (cnt_q != (AW+1)'(DEPTH));
  assign out_valid = cnt_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rp_q];
  // hold_q keeps the last head so a/out_err stay put once the buffer drains
  assign a         = out_valid ? head.a : hold_q.a;
  assign out_err   = out_valid ? head.err : hold_q.err;
  assign err_cnt   = ec_q;
  always_comb begin
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    hold_d = out_valid ? head : hold_q;
    ec_d   = clr_cnt ? '0 : (push && enc_err && ec_q != '1) ? ec_q + 1'b1 : ec_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      ec_q   <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      ec_q   <= ec_d;
      hold_q <= hold_d;
      if (push) mem_q[wp_q] <= '{a: enc_a, err: enc_err};
    end
  end
endmodule
